// File: rtl/warmboot_sequencer.sv
// iCE40 multi-image warm-boot controller: debounced image select, armed countdown, SB_WARMBOOT drive.
// Optional build macro WARMBOOT_SEQ_AUTO_BOOT_EN arms automatically after AUTO_TICKS idle ticks.

module warmboot_debounce #(
    parameter int LOG2 = 16
) (
    input  logic clk,
    input  logic resetn,
    input  logic raw,
    output logic rise
);
    // [0],[1] synchroniser; [2] holds the previous synced level for change detection
    logic [2:0]      sync_pipe;
    logic [LOG2-1:0] stab;
    logic            deb, deb_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_pipe <= '0;
            stab      <= '0;
            deb       <= 1'b0;
            deb_q     <= 1'b0;
            rise      <= 1'b0;
        end else begin
            sync_pipe <= {sync_pipe[1:0], raw};
            if (sync_pipe[1] != sync_pipe[2])
                stab <= '0;
            else if (!(&stab))
                stab <= stab + 1'b1;
            // sample the older tap so a change arriving this cycle can never slip through
            if (&stab)
                deb <= sync_pipe[2];
            deb_q <= deb;
            rise  <= deb & ~deb_q;
        end
    end
endmodule

module warmboot_sequencer #(
    parameter int LOG2DELAY     = 22,
    parameter int DEBOUNCE_LOG2 = 16,
    parameter int ARM_TICKS     = 8,
    parameter int DEFAULT_IMAGE = 0,
    parameter int AUTO_TICKS    = 32
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       btn_next,
    input  logic       btn_boot,
    output logic       wb_boot,
    output logic       wb_s1,
    output logic       wb_s0,
    output logic [3:0] led_img,
    output logic       led_hb,
    output logic       led_arm
);
    localparam logic [1:0] DEF_IMG    = 2'(DEFAULT_IMAGE);
    localparam logic [3:0] DEF_ONEHOT = 4'b0001 << DEFAULT_IMAGE;
    localparam logic [7:0] ARM_INIT   = 8'(ARM_TICKS);

    if (ARM_TICKS < 1 || ARM_TICKS > 255 || DEFAULT_IMAGE < 0 || DEFAULT_IMAGE > 3 ||
        AUTO_TICKS < 1 || AUTO_TICKS > 65535 || LOG2DELAY < 1 || DEBOUNCE_LOG2 < 1) begin : g_param_err
        $error("warmboot_sequencer: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, ARM, BOOT} state_t;

    state_t               state, state_nxt;
    logic [1:0]           image, image_nxt;
    logic [7:0]           arm_cnt, arm_cnt_nxt;
    logic [LOG2DELAY-1:0] presc;
    logic                 tick;
    logic [1:0]           btn_raw, btn_rise;
    logic                 next_edge, boot_edge;

    assign tick      = &presc;
    assign btn_raw   = {btn_boot, btn_next};
    assign next_edge = btn_rise[0];
    assign boot_edge = btn_rise[1];

    genvar i;
    for (i = 0; i < 2; i++) begin : g_btn
        warmboot_debounce #(.LOG2(DEBOUNCE_LOG2)) u_deb (
            .clk    (clk),
            .resetn (resetn),
            .raw    (btn_raw[i]),
            .rise   (btn_rise[i])
        );
    end

`ifdef WARMBOOT_SEQ_AUTO_BOOT_EN
    localparam logic [15:0] AUTO_LAST = 16'(AUTO_TICKS - 1);
    logic [15:0] idle_cnt, idle_cnt_nxt;
`endif

    always_comb begin
        state_nxt   = state;
        image_nxt   = image;
        arm_cnt_nxt = arm_cnt;
`ifdef WARMBOOT_SEQ_AUTO_BOOT_EN
        idle_cnt_nxt = idle_cnt;
`endif
        case (state)
            IDLE: begin
                // next and boot together: the incremented image is the one armed
                if (next_edge)
                    image_nxt = image + 2'd1;
                if (boot_edge) begin
                    state_nxt   = ARM;
                    arm_cnt_nxt = ARM_INIT;
                end
`ifdef WARMBOOT_SEQ_AUTO_BOOT_EN
                if (next_edge || boot_edge) begin
                    idle_cnt_nxt = '0;
                end else if (tick) begin
                    if (idle_cnt == AUTO_LAST) begin
                        state_nxt    = ARM;
                        arm_cnt_nxt  = ARM_INIT;
                        idle_cnt_nxt = '0;
                    end else begin
                        idle_cnt_nxt = idle_cnt + 16'd1;
                    end
                end
`endif
            end
            ARM: begin
                // cancel beats the final tick
                if (boot_edge) begin
                    state_nxt = IDLE;
`ifdef WARMBOOT_SEQ_AUTO_BOOT_EN
                    idle_cnt_nxt = '0;
`endif
                end else if (tick) begin
                    arm_cnt_nxt = arm_cnt - 8'd1;
                    if (arm_cnt == 8'd1)
                        state_nxt = BOOT;
                end
            end
            BOOT: ;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state          <= IDLE;
            image          <= DEF_IMG;
            arm_cnt        <= '0;
            presc          <= '0;
            wb_boot        <= 1'b0;
            {wb_s1, wb_s0} <= DEF_IMG;
            led_img        <= DEF_ONEHOT;
            led_hb         <= 1'b0;
            led_arm        <= 1'b0;
`ifdef WARMBOOT_SEQ_AUTO_BOOT_EN
            idle_cnt       <= '0;
`endif
        end else begin
            state   <= state_nxt;
            image   <= image_nxt;
            arm_cnt <= arm_cnt_nxt;
            presc   <= presc + 1'b1;
            if (tick)
                led_hb <= ~led_hb;
            // BOOT rises a cycle after entry so S1/S0 have already settled
            wb_boot <= (state == BOOT);
            if (state == IDLE)
                {wb_s1, wb_s0} <= image_nxt;
            led_img <= 4'b0001 << image_nxt;
            led_arm <= (state_nxt != IDLE);
`ifdef WARMBOOT_SEQ_AUTO_BOOT_EN
            idle_cnt <= idle_cnt_nxt;
`endif
        end
    end
endmodule

// File: tb/tb_warmboot_sequencer.sv
// Bench for warmboot_sequencer: event-level model (button edges scheduled at press time,
// ticks and boot instants from edge arithmetic) compared every cycle, plus literal spot checks.
module tb_warmboot_sequencer;
    localparam int TP     = 16;            // 2^LOG2DELAY
    localparam int DEBC   = 4;             // 2^DEBOUNCE_LOG2
    localparam int LAT    = DEBC + 5;      // raw press -> FSM reacts at this edge (late end of window)
    localparam int ARM_T  = 3;
    localparam int AUTO_T = 5;

    logic       clk = 1'b0;
    logic       resetn = 1'b1;
    logic       btn_next = 1'b0;
    logic       btn_boot = 1'b0;
    logic       wb_boot, wb_s1, wb_s0, led_hb, led_arm;
    logic [3:0] led_img;

    warmboot_sequencer #(
        .LOG2DELAY(4), .DEBOUNCE_LOG2(2), .ARM_TICKS(ARM_T), .DEFAULT_IMAGE(0), .AUTO_TICKS(AUTO_T)
    ) dut (
        .clk(clk), .resetn(resetn), .btn_next(btn_next), .btn_boot(btn_boot),
        .wb_boot(wb_boot), .wb_s1(wb_s1), .wb_s0(wb_s0),
        .led_img(led_img), .led_hb(led_hb), .led_arm(led_arm)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // model state: n = edges since reset release; armed stays set through BOOT
    int         n;
    bit         armed;
    int         boot_at;
    logic [1:0] img;
`ifdef WARMBOOT_SEQ_AUTO_BOOT_EN
    int         since;
`endif
    bit nx_at[int];
    bit bx_at[int];
    bit skip[int];

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (n=%0d)", nm, act, exp, n);
        end
    endtask

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            n       <= 0;
            armed   <= 1'b0;
            boot_at <= 0;
            img     <= 2'd0;
`ifdef WARMBOOT_SEQ_AUTO_BOOT_EN
            since   <= 0;
`endif
        end else begin
            n <= n + 1;
            if (!armed) begin
                if (nx_at.exists(n + 1)) begin
                    img <= img + 2'd1;
`ifdef WARMBOOT_SEQ_AUTO_BOOT_EN
                    since <= n + 1;
`endif
                end
                if (bx_at.exists(n + 1)) begin
                    armed   <= 1'b1;
                    boot_at <= ((n + 1) / TP + ARM_T) * TP;
                end
`ifdef WARMBOOT_SEQ_AUTO_BOOT_EN
                else if (!nx_at.exists(n + 1) && (n + 1) == (since / TP + AUTO_T) * TP) begin
                    armed   <= 1'b1;
                    boot_at <= ((n + 1) / TP + ARM_T) * TP;
                end
`endif
            end else if ((n + 1) <= boot_at && bx_at.exists(n + 1)) begin
                armed <= 1'b0;
`ifdef WARMBOOT_SEQ_AUTO_BOOT_EN
                since <= n + 1;
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (resetn && !skip.exists(n)) begin
            chk("wb_boot", {3'b0, wb_boot}, {3'b0, armed && (n > boot_at)});
            chk("led_arm", {3'b0, led_arm}, {3'b0, armed});
            chk("wb_s",    {2'b0, wb_s1, wb_s0}, {2'b0, img});
            chk("led_img", led_img, 4'b0001 << img);
            chk("led_hb",  {3'b0, led_hb}, {3'b0, 1'(n / TP)});
        end
    end

    task automatic wait_n(input int k);
        while (n < k) @(negedge clk);
    endtask

    // drive a clean press; 'at' is the edge count when the raw level went high
    task automatic press(input bit nxt, input bit bt, input bit aligned, input int hold, output int at);
        @(negedge clk);
        if (aligned)
            while (n % TP != 0) @(negedge clk);
        at = n;
        if (nxt) nx_at[n + LAT] = 1'b1;
        if (bt)  bx_at[n + LAT] = 1'b1;
        skip[n + LAT - 1] = 1'b1;
        btn_next = nxt;
        btn_boot = bt;
        repeat (hold) @(negedge clk);
        btn_next = 1'b0;
        btn_boot = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("rst_wb_boot", {3'b0, wb_boot}, 4'h0);
        chk("rst_led_img", led_img, 4'b0001);
        chk("rst_led_arm", {3'b0, led_arm}, 4'h0);
        chk("rst_wb_s",    {2'b0, wb_s1, wb_s0}, 4'h0);
        chk("rst_led_hb",  {3'b0, led_hb}, 4'h0);
        nx_at.delete();
        bx_at.delete();
        skip.delete();
        btn_next = 1'b0;
        btn_boot = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not end (n=%0d)", n);
        $fatal(1);
    end

    initial begin
        int at;
        #1 resetn = 1'b0;
        #1;
        chk("por_wb_boot", {3'b0, wb_boot}, 4'h0);
        chk("por_led_img", led_img, 4'b0001);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
`ifdef WARMBOOT_SEQ_AUTO_BOOT_EN
        wait_n(79);  chk("auto_pre_arm", {3'b0, led_arm}, 4'h0);
        wait_n(80);  chk("auto_arm", {3'b0, led_arm}, 4'h1);
        wait_n(128); chk("auto_boot_lo", {3'b0, wb_boot}, 4'h0);
        wait_n(129); chk("auto_boot_hi", {3'b0, wb_boot}, 4'h1);
        chk("auto_img", {2'b0, wb_s1, wb_s0}, 4'h0);
        do_reset();
        press(1'b0, 1'b1, 1'b1, 8, at);          // arm at 25, boot due at 64
        press(1'b0, 1'b1, 1'b0, 8, at);          // cancel before 64, idle count restarts
        wait_n(111); chk("auto_rearm_lo", {3'b0, led_arm}, 4'h0);
        wait_n(112); chk("auto_rearm_hi", {3'b0, led_arm}, 4'h1);
        wait_n(161); chk("auto_boot2", {3'b0, wb_boot}, 4'h1);
`else
        wait_n(15);  chk("hb_15", {3'b0, led_hb}, 4'h0);
        wait_n(16);  chk("hb_16", {3'b0, led_hb}, 4'h1);
        wait_n(32);  chk("hb_32", {3'b0, led_hb}, 4'h0);
        wait_n(200);
        chk("idle_wb_boot", {3'b0, wb_boot}, 4'h0);
        chk("idle_led_img", led_img, 4'b0001);
        repeat (5) press(1'b1, 1'b0, 1'b1, 20, at);
        chk("img5_led", led_img, 4'b0010);
        chk("img5_s",   {2'b0, wb_s1, wb_s0}, 4'h1);
        press(1'b1, 1'b0, 1'b1, 20, at);
        chk("img2_led", led_img, 4'b0100);
        press(1'b0, 1'b1, 1'b1, 20, at);
        wait_n(at + 40); chk("arm_led", {3'b0, led_arm}, 4'h1);
        wait_n(at + 48);
        chk("boot_pre_lo", {3'b0, wb_boot}, 4'h0);
        chk("boot_pre_s",  {2'b0, wb_s1, wb_s0}, 4'h2);
        wait_n(at + 49); chk("boot_hi", {3'b0, wb_boot}, 4'h1);
        repeat (100) @(negedge clk);
        chk("boot_held", {3'b0, wb_boot}, 4'h1);
        do_reset();
        press(1'b0, 1'b1, 1'b1, 8, at);          // arm, boot due at at+48
        press(1'b1, 1'b0, 1'b0, 8, at);          // ignored while armed
        press(1'b0, 1'b1, 1'b0, 8, at);          // cancel lands before the 3rd tick
        chk("cancel_arm", {3'b0, led_arm}, 4'h0);
        chk("cancel_img", led_img, 4'b0001);
        repeat (100) @(negedge clk);
        chk("cancel_no_boot", {3'b0, wb_boot}, 4'h0);
        @(negedge clk);
        btn_next = 1'b1;
        repeat (3) @(negedge clk);
        btn_next = 1'b0;
        repeat (30) @(negedge clk);
        chk("glitch_img", led_img, 4'b0001);
        repeat (1000) @(negedge clk);
        chk("long_idle_boot", {3'b0, wb_boot}, 4'h0);
        press(1'b1, 1'b1, 1'b1, 8, at);          // both at once: arm image 1
        wait_n(at + 49);
        chk("both_boot", {3'b0, wb_boot}, 4'h1);
        chk("both_s",    {2'b0, wb_s1, wb_s0}, 4'h1);
        chk("both_led",  led_img, 4'b0010);
`endif
        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
